// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM state encoding,
// BCD digit width, the blank code, and the shift-counter width helper.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BLANK_CODE = 4'hF;

  // The counter is loaded with BIN_W, so it needs room for the value BIN_W itself.
  function automatic int cnt_width(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/done bus between the calculator datapath and the converter.
//
// Handshake: the master raises start with bin valid. The converter accepts it
// on a rising edge only while idle or in its done cycle. busy is high for the
// BIN_W shift cycles. done is a one-cycle pulse, and bcd/ovf change only on
// the edge that raises done. start during busy is dropped, not queued.
// dbg_state exposes the converter FSM state for observation.
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  import calc_pkg::*;

  logic                      start;
  logic [BIN_W-1:0]          bin;
  logic                      busy;
  logic                      done;
  logic [BCD_W*DIGITS-1:0]   bcd;
  logic                      ovf;
  state_t                    dbg_state;

  modport master (
    output start, bin,
    input  busy, done, bcd, ovf, dbg_state
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, ovf, dbg_state
  );
endinterface

// File: rtl/bin_to_bcd_seq_bcd_add3.sv
// Double-dabble digit correction: any digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);
  // The input is at most 9, so the 4-bit sum never wraps.
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary to packed BCD converter.
// One conversion per accepted start, BIN_W shift cycles, then a one-cycle done.
// The result register holds the last completed value between conversions.
// Optional build macro BCD_LZB_EN: store digits above the most significant
// non-zero digit as the blank code (digit 0 never blanked, no blanking on ovf).
module bin_to_bcd_seq
  import calc_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  bin_to_bcd_seq_if.slave  bus
);

  localparam int CNT_W = cnt_width(BIN_W);
  localparam int DIG_W = BCD_W * DIGITS;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   sr_q, sr_d;
  logic [DIG_W-1:0]   dig_q, dig_d;
  logic               acc_q, acc_d;
  logic [DIG_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;

  logic [DIG_W-1:0]   corr;
  logic [DIG_W-1:0]   dig_next;
  logic [BIN_W-1:0]   sr_next;
  logic               acc_next;
  logic [DIG_W-1:0]   bcd_final;

  // Per-digit add-3 correction on the current working digits.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d (dig_q[g*BCD_W +: BCD_W]),
      .q (corr[g*BCD_W +: BCD_W])
    );
  end

`ifdef BCD_LZB_EN
  // Replace leading zero digits with the blank code; digit 0 is always kept.
  function automatic logic [DIG_W-1:0] lzb_blank(input logic [DIG_W-1:0] raw,
                                                  input logic ovf);
    logic [DIG_W-1:0] r;
    logic             seen;
    r    = raw;
    seen = ovf;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (raw[i*BCD_W +: BCD_W] != '0) seen = 1'b1;
      if (!seen) r[i*BCD_W +: BCD_W] = BLANK_CODE;
    end
    return r;
  endfunction
`endif

  // One shift step: {digits, shift register} << 1 after correction; the bit
  // pushed out of the top digit marks a result too wide for DIGITS digits.
  always_comb begin
    dig_next = {corr[DIG_W-2:0], sr_q[BIN_W-1]};
    sr_next  = {sr_q[BIN_W-2:0], 1'b0};
    acc_next = acc_q | corr[DIG_W-1];
`ifdef BCD_LZB_EN
    bcd_final = lzb_blank(dig_next, acc_next);
`else
    bcd_final = dig_next;
`endif
  end

  // Next-state, counter, working registers and result register update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    dig_d   = dig_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          sr_d    = bus.bin;
          dig_d   = '0;
          acc_d   = 1'b0;
          cnt_d   = CNT_W'(BIN_W);
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        sr_d  = sr_next;
        dig_d = dig_next;
        acc_d = acc_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = bcd_final;
          ovf_d   = acc_next;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      dig_q   <= '0;
      acc_q   <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      dig_q   <= dig_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy      = (state_q == SHIFT);
  assign bus.done      = (state_q == DONE);
  assign bus.bcd       = bcd_q;
  assign bus.ovf       = ovf_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: a 3-digit and a 2-digit instance share
// clock and reset. Expected values are hand-computed table entries, with a
// raw and a blanked column chosen by the BCD_LZB_EN build macro.
module tb_bin_to_bcd_seq;
  import calc_pkg::*;

`ifdef BCD_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic clk;
  logic rst_n;

  bin_to_bcd_seq_if #(.BIN_W(8), .DIGITS(3)) if3 ();
  bin_to_bcd_seq_if #(.BIN_W(8), .DIGITS(2)) if2 ();

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));
  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [11:0] last3 = '0;
  logic [11:0] last2 = '0;

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] raw;
    logic [11:0] lzb;
    logic        ovf;
  } vec_t;

  vec_t vec3 [9];
  vec_t vec2 [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int which, input logic s, input logic [7:0] b);
    if (which == 3) begin
      if3.start = s;
      if3.bin   = b;
    end else begin
      if2.start = s;
      if2.bin   = b;
    end
  endtask

  task automatic sample(input int which, output logic busy, output logic done,
                        output logic [11:0] bcd, output logic ovf);
    if (which == 3) begin
      busy = if3.busy; done = if3.done; bcd = if3.bcd; ovf = if3.ovf;
    end else begin
      busy = if2.busy; done = if2.done; bcd = {4'h0, if2.bcd}; ovf = if2.ovf;
    end
  endtask

  // One isolated conversion, entered and left at a negedge in IDLE.
  task automatic run_vec(input int which, input logic [7:0] b,
                         input logic [11:0] exp_bcd, input logic exp_ovf, input string name);
    logic busy, done, ovf;
    logic [11:0] bcd, prev;
    int bad_busy, bad_hold;
    prev = (which == 3) ? last3 : last2;
    bad_busy = 0;
    bad_hold = 0;
    drive(which, 1'b1, b);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) drive(which, 1'b0, ~b);
      sample(which, busy, done, bcd, ovf);
      if (!(busy === 1'b1 && done === 1'b0)) bad_busy++;
      if (bcd !== prev) bad_hold++;
    end
    check({name, "_busy_c1_8_bad"}, bad_busy, 0);
    check({name, "_bcd_hold_bad"}, bad_hold, 0);
    @(negedge clk);
    sample(which, busy, done, bcd, ovf);
    check({name, "_done_c9"}, {busy, done}, 2'b01);
    check({name, "_bcd"}, bcd, exp_bcd);
    check({name, "_ovf"}, ovf, exp_ovf);
    @(negedge clk);
    sample(which, busy, done, bcd, ovf);
    check({name, "_done_pulse_end"}, {busy, done}, 2'b00);
    check({name, "_bcd_held"}, bcd, exp_bcd);
    if (which == 3) last3 = exp_bcd; else last2 = exp_bcd;
  endtask

  initial begin
    logic busy, done, ovf;
    logic [11:0] bcd;
    int bad_busy, bad_done, bad_nodone;

    //           bin    raw      blanked  ovf
    vec3[0] = '{8'd255, 12'h255, 12'h255, 1'b0};
    vec3[1] = '{8'd0,   12'h000, 12'hFF0, 1'b0};
    vec3[2] = '{8'd7,   12'h007, 12'hFF7, 1'b0};
    vec3[3] = '{8'd40,  12'h040, 12'hF40, 1'b0};
    vec3[4] = '{8'd100, 12'h100, 12'h100, 1'b0};
    vec3[5] = '{8'd99,  12'h099, 12'hF99, 1'b0};
    vec3[6] = '{8'd128, 12'h128, 12'h128, 1'b0};
    vec3[7] = '{8'd10,  12'h010, 12'hF10, 1'b0};
    vec3[8] = '{8'd1,   12'h001, 12'hFF1, 1'b0};

    vec2[0] = '{8'd100, 12'h000, 12'h000, 1'b1};
    vec2[1] = '{8'd99,  12'h099, 12'h099, 1'b0};
    vec2[2] = '{8'd5,   12'h005, 12'h0F5, 1'b0};
    vec2[3] = '{8'd255, 12'h055, 12'h055, 1'b1};
    vec2[4] = '{8'd10,  12'h010, 12'h010, 1'b0};
    vec2[5] = '{8'd0,   12'h000, 12'h0F0, 1'b0};

    rst_n = 1'b0;
    drive(3, 1'b0, 8'd0);
    drive(2, 1'b0, 8'd0);
    #22;
    sample(3, busy, done, bcd, ovf);
    check("rst3_outputs", {busy, done, ovf, bcd}, 15'd0);
    check("rst3_state", if3.dbg_state, IDLE);
    sample(2, busy, done, bcd, ovf);
    check("rst2_outputs", {busy, done, ovf, bcd}, 15'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven conversions on the 3-digit instance
    for (int i = 0; i < 9; i++)
      run_vec(3, vec3[i].bin, LZB ? vec3[i].lzb : vec3[i].raw, vec3[i].ovf,
              $sformatf("d3_bin%0d", vec3[i].bin));

    // Back-to-back: start held for 9 then 200; start pulse and bin changes mid-shift
    bad_busy = 0;
    bad_done = 0;
    drive(3, 1'b1, 8'd9);
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      sample(3, busy, done, bcd, ovf);
      if (busy !== ((c >= 1 && c <= 8) || (c >= 10 && c <= 17))) bad_busy++;
      if (done !== (c == 9 || c == 18)) bad_done++;
      if (c == 9)  check("b2b_first_bcd", bcd, LZB ? 12'hFF9 : 12'h009);
      if (c == 18) check("b2b_second_bcd", bcd, 12'h200);
      if (c == 5)  check("b2b_hold_mid1", bcd, last3);
      if (c == 14) check("b2b_hold_mid2", bcd, LZB ? 12'hFF9 : 12'h009);
      case (c)
        1:  drive(3, 1'b1, 8'd200);
        4:  drive(3, 1'b1, 8'd33);
        8:  drive(3, 1'b1, 8'd200);
        10: drive(3, 1'b0, 8'd200);
        12: drive(3, 1'b1, 8'd77);
        13: drive(3, 1'b0, 8'd55);
        18: drive(3, 1'b0, 8'd0);
        default: ;
      endcase
    end
    check("b2b_busy_bad", bad_busy, 0);
    check("b2b_done_bad", bad_done, 0);
    last3 = 12'h200;

    // Reset asserted during cycle 4 of a conversion
    drive(3, 1'b1, 8'd255);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) drive(3, 1'b0, 8'd0);
    end
    sample(3, busy, done, bcd, ovf);
    check("midrst_busy_before", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    sample(3, busy, done, bcd, ovf);
    check("midrst_outputs_zero", {busy, done, ovf, bcd}, 15'd0);
    check("midrst_state", if3.dbg_state, IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    last3 = '0;
    last2 = '0;
    bad_nodone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      sample(3, busy, done, bcd, ovf);
      if (done !== 1'b0 || busy !== 1'b0 || bcd !== 12'h000) bad_nodone++;
    end
    check("midrst_no_done_bad", bad_nodone, 0);
    run_vec(3, 8'd42, LZB ? 12'hF42 : 12'h042, 1'b0, "midrst_then_42");

    // Table-driven conversions on the 2-digit instance (overflow boundary)
    for (int i = 0; i < 6; i++)
      run_vec(2, vec2[i].bin, LZB ? vec2[i].lzb : vec2[i].raw, vec2[i].ovf,
              $sformatf("d2_bin%0d", vec2[i].bin));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
